// File: rtl/rx_control.sv
// Receive controller: writes MAC bytes into the data buffer and pushes one
// {bad, length} word per frame into the length buffer, with frame statistics.
module rx_control #(
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_valid,
    input  logic             rx_last_byte,
    input  logic             rx_error,
    input  logic             full_buff,
    input  logic             full_len_buff,
    output logic [7:0]       buf_data,
    output logic             buf_wr,
    output logic [16:0]      len_data,
    output logic             len_wr,
    output logic             rx_frame,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] dropped_frames
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_RECV   = 4'b0010,
        S_DROP   = 4'b0100,
        S_COMMIT = 4'b1000
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [LEN_W-1:0]   count_q;
    logic [LEN_W-1:0]   count_d;
    logic               bad_q;
    logic               bad_d;
    logic               start_drop;
    logic               frame_bad;
    logic               buf_wr_d;
    logic [BYTE_W-1:0]  buf_data_d;
    logic               len_wr_d;
    logic [LEN_W:0]     len_data_d;
    logic               rx_frame_d;
    logic [CNT_W-1:0]   good_d;
    logic [CNT_W-1:0]   dropped_d;
    logic               any_full_c;
    logic               trunc_c;

    assign any_full_c = full_buff | full_len_buff;
    assign trunc_c    = full_buff | (count_q == LEN_W'(MAX_LEN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // COMMIT lasts one cycle but accepts a new first byte, so it shares IDLE's start rules.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_COMMIT: begin
                state_d = S_IDLE;
                if (rx_data_valid) begin
                    if (any_full_c) begin
                        state_d = rx_last_byte ? S_IDLE : S_DROP;
                    end else begin
                        state_d = rx_last_byte ? S_COMMIT : S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (rx_data_valid) begin
                    if (rx_last_byte) begin
                        state_d = S_COMMIT;
                    end else if (trunc_c) begin
                        state_d = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (rx_data_valid && rx_last_byte) begin
                    state_d = (count_q != '0) ? S_COMMIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d    = count_q;
        bad_d      = bad_q;
        start_drop = 1'b0;
        buf_wr_d   = 1'b0;
        buf_data_d = buf_data;
        case (state_q)
            S_IDLE, S_COMMIT: begin
                if (state_q == S_COMMIT) begin
                    count_d = '0;
                    bad_d   = 1'b0;
                end
                if (rx_data_valid) begin
                    if (any_full_c) begin
                        start_drop = 1'b1;
                    end else begin
                        buf_wr_d   = 1'b1;
                        buf_data_d = rx_data;
                        count_d    = LEN_W'(1);
                        bad_d      = rx_error;
                    end
                end
            end
            S_RECV: begin
                if (rx_data_valid) begin
                    if (trunc_c) begin
                        bad_d = 1'b1;
                    end else begin
                        buf_wr_d   = 1'b1;
                        buf_data_d = rx_data;
                        count_d    = count_q + LEN_W'(1);
                        bad_d      = bad_q | rx_error;
                    end
                end
            end
            S_DROP: begin
            end
            default: begin
                count_d = '0;
                bad_d   = 1'b0;
            end
        endcase

        // Length word and statistics are registered on entry so they appear with len_wr.
        len_wr_d   = (state_d == S_COMMIT);
        frame_bad  = bad_d | (count_d < LEN_W'(MIN_LEN));
        len_data_d = len_wr_d ? {frame_bad, count_d} : len_data;
        rx_frame_d = (state_d == S_RECV) || (state_d == S_DROP);
        good_d     = good_frames;
        dropped_d  = dropped_frames;
        if (len_wr_d && !frame_bad) begin
            good_d = good_frames + CNT_W'(1);
        end else if (len_wr_d || start_drop) begin
            dropped_d = dropped_frames + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q        <= '0;
            bad_q          <= 1'b0;
            buf_wr         <= 1'b0;
            buf_data       <= '0;
            len_wr         <= 1'b0;
            len_data       <= '0;
            rx_frame       <= 1'b0;
            good_frames    <= '0;
            dropped_frames <= '0;
        end else begin
            count_q        <= count_d;
            bad_q          <= bad_d;
            buf_wr         <= buf_wr_d;
            buf_data       <= buf_data_d;
            len_wr         <= len_wr_d;
            len_data       <= len_data_d;
            rx_frame       <= rx_frame_d;
            good_frames    <= good_d;
            dropped_frames <= dropped_d;
        end
    end

endmodule

// File: tb/tb_rx_control.sv
// Bench for rx_control: frame-level model predicts every write, length word
// and rx_frame level; a negedge monitor compares them cycle by cycle.
module tb_rx_control;

    localparam int unsigned MIN_LEN = 60;
    localparam int unsigned MAX_LEN = 1518;
    localparam int unsigned CNT_W   = 16;
    localparam int          MAX_CYC = 8192;

    localparam int K_MARK  = 0;
    localparam int K_GOOD  = 1;
    localparam int K_DROP  = 2;
    localparam int K_NWR   = 3;
    localparam int K_NLEN  = 4;
    localparam int K_LAST  = 5;
    localparam int K_PREV  = 6;
    localparam int K_WQ    = 7;
    localparam int K_LQ    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_data = '0;
    logic             rx_data_valid = 1'b0;
    logic             rx_last_byte = 1'b0;
    logic             rx_error = 1'b0;
    logic             full_buff = 1'b0;
    logic             full_len_buff = 1'b0;
    logic [7:0]       buf_data;
    logic             buf_wr;
    logic [16:0]      len_data;
    logic             len_wr;
    logic             rx_frame;
    logic [CNT_W-1:0] good_frames;
    logic [CNT_W-1:0] dropped_frames;

    rx_control #(
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_last_byte  (rx_last_byte),
        .rx_error      (rx_error),
        .full_buff     (full_buff),
        .full_len_buff (full_len_buff),
        .buf_data      (buf_data),
        .buf_wr        (buf_wr),
        .len_data      (len_data),
        .len_wr        (len_wr),
        .rx_frame      (rx_frame),
        .good_frames   (good_frames),
        .dropped_frames(dropped_frames)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [16:0] val;
    } exp_t;

    typedef struct {
        int kind;
        int val;
    } lit_t;

    exp_t        exp_wr[$];
    exp_t        exp_len[$];
    lit_t        lit_q[$];
    bit          exp_rxf [MAX_CYC];
    bit          mf = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_wr = 0;
    int          n_len = 0;
    logic [16:0] last_len = '0;
    logic [16:0] prev_len = '0;

    function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Single compare process: streams against the model, then queued literal checks.
    always @(negedge clk) begin
        bit   ew;
        bit   el;
        lit_t l;
        if (!rst) begin
            chk({buf_wr, len_wr, rx_frame, buf_data, len_data, good_frames, dropped_frames} == '0,
                "reset_zero",
                longint'({buf_wr, len_wr, rx_frame, buf_data, len_data, good_frames, dropped_frames}), 0);
        end else begin
            ew = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
            chk(buf_wr == ew, "buf_wr", longint'(buf_wr), longint'(ew));
            if (ew) begin
                chk(buf_data == exp_wr[0].val[7:0], "buf_data", longint'(buf_data), longint'(exp_wr[0].val[7:0]));
                void'(exp_wr.pop_front());
            end
            el = (exp_len.size() > 0) && (exp_len[0].cyc == cyc);
            chk(len_wr == el, "len_wr", longint'(len_wr), longint'(el));
            if (el) begin
                chk(len_data == exp_len[0].val, "len_data", longint'(len_data), longint'(exp_len[0].val));
                void'(exp_len.pop_front());
            end
            chk(rx_frame == exp_rxf[cyc], "rx_frame", longint'(rx_frame), longint'(exp_rxf[cyc]));
            if (buf_wr) n_wr++;
            if (len_wr) begin
                n_len++;
                prev_len = last_len;
                last_len = len_data;
            end
        end
        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            case (l.kind)
                K_MARK: begin
                    n_wr  = 0;
                    n_len = 0;
                end
                K_GOOD: chk(good_frames == CNT_W'(l.val), "good_frames", longint'(good_frames), longint'(l.val));
                K_DROP: chk(dropped_frames == CNT_W'(l.val), "dropped_frames", longint'(dropped_frames), longint'(l.val));
                K_NWR:  chk(n_wr == l.val, "buf_wr_count", longint'(n_wr), longint'(l.val));
                K_NLEN: chk(n_len == l.val, "len_wr_count", longint'(n_len), longint'(l.val));
                K_LAST: chk(last_len == 17'(l.val), "last_len_word", longint'(last_len), longint'(l.val));
                K_PREV: chk(prev_len == 17'(l.val), "prev_len_word", longint'(prev_len), longint'(l.val));
                K_WQ:   chk(exp_wr.size() == 0, "wr_queue_drained", longint'(exp_wr.size()), 0);
                K_LQ:   chk(exp_len.size() == 0, "len_queue_drained", longint'(exp_len.size()), 0);
                default: ;
            endcase
        end
    end

    task automatic lit(input int k, input int v);
        lit_q.push_back('{kind: k, val: v});
    endtask

    // One input cycle; the model's rx_frame level follows the last valid byte's "last" flag.
    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic e,
                        input logic fb, input logic fl, output int c);
        @(posedge clk);
        #1;
        rx_data_valid = v;
        rx_data       = d;
        rx_last_byte  = l;
        rx_error      = e;
        full_buff     = fb;
        full_len_buff = fl;
        c = cyc;
        if (v) mf = !l;
        if (c + 1 >= MAX_CYC) begin
            $display("FAIL cycle_budget: got %0d, limit %0d", c + 1, MAX_CYC);
            $fatal(1, "cycle budget exhausted");
        end
        exp_rxf[c + 1] = mf;
    endtask

    task automatic idle(input int n);
        int c;
        repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endtask

    // Frame-level model: which bytes land in the buffer and what length word follows.
    task automatic send_frame(input int n, input logic [7:0] base, input int err_pos,
                              input int full_at, input bit lenfull);
        int         nw;
        bit         drop0;
        bit         bad;
        int         c;
        logic [7:0] d;
        drop0 = lenfull || (full_at == 1);
        nw = drop0 ? 0 : ((n > int'(MAX_LEN)) ? int'(MAX_LEN) : n);
        if (!drop0 && full_at > 1 && full_at - 1 < nw) nw = full_at - 1;
        bad = (nw < n) || (err_pos >= 1 && err_pos <= n) || (nw < int'(MIN_LEN));
        for (int i = 1; i <= n; i++) begin
            d = base + 8'(i - 1);
            step(1'b1, d, i == n, i == err_pos, i == full_at, lenfull && (i == 1), c);
            if (i <= nw) exp_wr.push_back('{cyc: c + 1, val: 17'(d)});
            if (i == n && !drop0) exp_len.push_back('{cyc: c + 1, val: {bad, 16'(nw)}});
        end
    endtask

    task automatic expect_frame(input int nwr, input int nlen, input int good, input int drop);
        lit(K_NWR, nwr);
        lit(K_NLEN, nlen);
        lit(K_GOOD, good);
        lit(K_DROP, drop);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        mf            = 1'b0;
        rx_data_valid = 1'b0;
        idle(n);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int c;
        #2 rst = 1'b0;
        idle(3);
        @(posedge clk);
        #1 rst = 1'b1;
        lit(K_GOOD, 0);
        lit(K_DROP, 0);

        // 64-byte good frame
        lit(K_MARK, 0);
        send_frame(64, 8'h00, 0, 0, 1'b0);
        idle(3);
        expect_frame(64, 1, 1, 0);
        lit(K_LAST, 17'h00040);

        // 20-byte runt
        lit(K_MARK, 0);
        send_frame(20, 8'h80, 0, 0, 1'b0);
        idle(3);
        expect_frame(20, 1, 1, 1);
        lit(K_LAST, 17'h10014);

        // 1600-byte oversize, truncated at MAX_LEN
        lit(K_MARK, 0);
        send_frame(1600, 8'h00, 0, 0, 1'b0);
        idle(3);
        expect_frame(1518, 1, 1, 2);
        lit(K_LAST, 17'h105EE);

        // length buffer full at start: whole frame dropped, next frame normal
        lit(K_MARK, 0);
        send_frame(100, 8'h00, 0, 0, 1'b1);
        idle(3);
        expect_frame(0, 0, 1, 3);
        lit(K_MARK, 0);
        send_frame(100, 8'h40, 0, 0, 1'b0);
        idle(3);
        expect_frame(100, 1, 2, 3);
        lit(K_LAST, 17'h00064);

        // back-to-back 60-byte frames, error on byte 30 of the second
        lit(K_MARK, 0);
        send_frame(60, 8'h10, 0, 0, 1'b0);
        send_frame(60, 8'h50, 30, 0, 1'b0);
        idle(3);
        expect_frame(120, 2, 3, 4);
        lit(K_PREV, 17'h0003C);
        lit(K_LAST, 17'h1003C);

        // data buffer full mid-frame at byte 50 of 80
        lit(K_MARK, 0);
        send_frame(80, 8'hA0, 0, 50, 1'b0);
        idle(3);
        expect_frame(49, 1, 3, 5);
        lit(K_LAST, 17'h10031);

        // reset after byte 40 of an unfinished frame
        lit(K_MARK, 0);
        for (int i = 1; i <= 40; i++) begin
            logic [7:0] d;
            d = 8'(i);
            step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, c);
            exp_wr.push_back('{cyc: c + 1, val: 17'(d)});
        end
        idle(1);
        do_reset(3);
        idle(2);
        expect_frame(40, 0, 0, 0);
        lit(K_MARK, 0);
        send_frame(60, 8'h20, 0, 0, 1'b0);
        idle(3);
        expect_frame(60, 1, 1, 0);
        lit(K_LAST, 17'h0003C);

        lit(K_WQ, 0);
        lit(K_LQ, 0);
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
